// File: rtl/slot_release_tracker.sv
// Free-slot bitmap for a WIDTH-entry structure: two allocations clear bits and two releases set bits each cycle.
// Define SLOT_RELEASE_CHECK_EN to build the sticky protocol checker behind err/err_code.
module slot_release_tracker #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [1:0]       alloc_valid,
  input  logic [IDX_W-1:0] alloc_idx1,
  input  logic [IDX_W-1:0] alloc_idx2,
  input  logic [1:0]       rel_valid,
  input  logic [IDX_W-1:0] rel_idx1,
  input  logic [IDX_W-1:0] rel_idx2,
  output logic [WIDTH-1:0] free_vec,
  output logic [CNT_W-1:0] free_count,
  output logic             all_free,
  output logic             none_free,
  output logic             two_free,
  output logic             err,
  output logic [2:0]       err_code
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] TWO_CNT  = CNT_W'(2);

  logic [WIDTH-1:0] free_vec_q, free_vec_d;
  logic [CNT_W-1:0] free_count_q, free_count_d;
  logic [WIDTH-1:0] alloc_mask, rel_mask;

  // Indices at or beyond WIDTH match no bit, so they decode to an empty mask.
  function automatic logic [WIDTH-1:0] onehot(input logic [IDX_W-1:0] idx, input logic en);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (en && (idx == IDX_W'(i))) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  // The count is always the popcount of the next bitmap, never a separate up/down counter.
  always_comb begin
    alloc_mask = onehot(alloc_idx1, alloc_valid[0]) | onehot(alloc_idx2, alloc_valid[1]);
    rel_mask   = onehot(rel_idx1, rel_valid[0]) | onehot(rel_idx2, rel_valid[1]);
    if (flush) begin
      free_vec_d = '1;
    end else begin
      free_vec_d = (free_vec_q & ~alloc_mask) | rel_mask;
    end
    free_count_d = popcount(free_vec_d);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      free_vec_q   <= '1;
      free_count_q <= FULL_CNT;
    end else begin
      free_vec_q   <= free_vec_d;
      free_count_q <= free_count_d;
    end
  end

  assign free_vec   = free_vec_q;
  assign free_count = free_count_q;
  assign all_free   = (free_count_q == FULL_CNT);
  assign none_free  = (free_count_q == '0);
  assign two_free   = (free_count_q >= TWO_CNT);

`ifdef SLOT_RELEASE_CHECK_EN
  logic [2:0] err_code_q, err_code_d;
  logic       dbl_free, busy_alloc, bad_idx;

  // Every check looks at the registered bitmap, before this cycle's updates.
  always_comb begin
    dbl_free = (rel_valid[0] && |(onehot(rel_idx1, 1'b1) & free_vec_q)) ||
               (rel_valid[1] && |(onehot(rel_idx2, 1'b1) & free_vec_q)) ||
               ((&rel_valid) && (rel_idx1 == rel_idx2)) ||
               (all_free && (|rel_valid));
    busy_alloc = (alloc_valid[0] && |(onehot(alloc_idx1, 1'b1) & ~free_vec_q)) ||
                 (alloc_valid[1] && |(onehot(alloc_idx2, 1'b1) & ~free_vec_q)) ||
                 (none_free && (|alloc_valid));
    bad_idx = (alloc_valid[0] && !(|onehot(alloc_idx1, 1'b1))) ||
              (alloc_valid[1] && !(|onehot(alloc_idx2, 1'b1))) ||
              (rel_valid[0]   && !(|onehot(rel_idx1, 1'b1)))   ||
              (rel_valid[1]   && !(|onehot(rel_idx2, 1'b1)));
    err_code_d = err_code_q;
    if (!flush) begin
      err_code_d = err_code_q | {bad_idx, busy_alloc, dbl_free};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_code_q <= 3'b000;
    end else begin
      err_code_q <= err_code_d;
    end
  end

  assign err      = |err_code_q;
  assign err_code = err_code_q;
`else
  assign err      = 1'b0;
  assign err_code = 3'b000;
`endif

endmodule

// File: tb/tb_slot_release_tracker.sv
// Randomized bench for slot_release_tracker: two instances (WIDTH=8 and WIDTH=5) against a slot-level reference model.
module tb_slot_release_tracker;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic [1:0] alloc_valid = 2'b00;
  logic [2:0] alloc_idx1 = 3'd0, alloc_idx2 = 3'd0;
  logic [1:0] rel_valid = 2'b00;
  logic [2:0] rel_idx1 = 3'd0, rel_idx2 = 3'd0;

  logic [7:0] fv8;
  logic [3:0] cnt8;
  logic       af8, nf8, tf8, er8;
  logic [2:0] ec8;
  logic [4:0] fv5;
  logic [2:0] cnt5;
  logic       af5, nf5, tf5, er5;
  logic [2:0] ec5;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] m_fv [2];
  logic [2:0] m_ec [2];

  always #5 clock = ~clock;

  slot_release_tracker #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_idx1(alloc_idx1), .alloc_idx2(alloc_idx2),
    .rel_valid(rel_valid), .rel_idx1(rel_idx1), .rel_idx2(rel_idx2),
    .free_vec(fv8), .free_count(cnt8), .all_free(af8), .none_free(nf8),
    .two_free(tf8), .err(er8), .err_code(ec8)
  );

  slot_release_tracker #(.WIDTH(5)) u_dut5 (
    .clock(clock), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_idx1(alloc_idx1), .alloc_idx2(alloc_idx2),
    .rel_valid(rel_valid), .rel_idx1(rel_idx1), .rel_idx2(rel_idx2),
    .free_vec(fv5), .free_count(cnt5), .all_free(af5), .none_free(nf5),
    .two_free(tf5), .err(er5), .err_code(ec5)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int wid(input int k);
    return (k == 0) ? 8 : 5;
  endfunction

  function automatic int popc(input logic [7:0] v);
    int c = 0;
    for (int i = 0; i < 8; i++) if (v[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_fv[k] = 8'((1 << wid(k)) - 1);
      m_ec[k] = 3'b000;
    end
  endtask

  // Slot-by-slot rules: allocations free nothing up, releases are applied last so they win.
  task automatic model_step(input logic fl, input logic [1:0] av, input int a1, input int a2,
                            input logic [1:0] rv, input int r1, input int r2);
    int ai [2];
    int ri [2];
    ai[0] = a1; ai[1] = a2; ri[0] = r1; ri[1] = r2;
    for (int k = 0; k < 2; k++) begin
      int w;
      int cnt;
      logic [7:0] old;
      logic [7:0] nxt;
      w = wid(k);
      old = m_fv[k];
      cnt = popc(old);
      if (fl) begin
        m_fv[k] = 8'((1 << w) - 1);
      end else begin
        nxt = old;
        for (int p = 0; p < 2; p++) if (av[p] && ai[p] < w) nxt[ai[p]] = 1'b0;
        for (int p = 0; p < 2; p++) if (rv[p] && ri[p] < w) nxt[ri[p]] = 1'b1;
`ifdef SLOT_RELEASE_CHECK_EN
        for (int p = 0; p < 2; p++) begin
          if (rv[p]) begin
            if (ri[p] >= w) m_ec[k][2] = 1'b1;
            else if (old[ri[p]]) m_ec[k][0] = 1'b1;
          end
          if (av[p]) begin
            if (ai[p] >= w) m_ec[k][2] = 1'b1;
            else if (!old[ai[p]]) m_ec[k][1] = 1'b1;
          end
        end
        if (rv == 2'b11 && r1 == r2) m_ec[k][0] = 1'b1;
        if (cnt == w && rv != 2'b00) m_ec[k][0] = 1'b1;
        if (cnt == 0 && av != 2'b00) m_ec[k][1] = 1'b1;
`endif
        m_fv[k] = nxt;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      int w;
      int c;
      logic [31:0] g_fv, g_cnt, g_af, g_nf, g_tf, g_er, g_ec;
      w = wid(k);
      c = popc(m_fv[k]);
      g_fv  = (k == 0) ? 32'(fv8)  : 32'(fv5);
      g_cnt = (k == 0) ? 32'(cnt8) : 32'(cnt5);
      g_af  = (k == 0) ? 32'(af8)  : 32'(af5);
      g_nf  = (k == 0) ? 32'(nf8)  : 32'(nf5);
      g_tf  = (k == 0) ? 32'(tf8)  : 32'(tf5);
      g_er  = (k == 0) ? 32'(er8)  : 32'(er5);
      g_ec  = (k == 0) ? 32'(ec8)  : 32'(ec5);
      check_eq($sformatf("%s w%0d free_vec", tag, w), g_fv, 32'(m_fv[k]));
      check_eq($sformatf("%s w%0d free_count", tag, w), g_cnt, 32'(c));
      check_eq($sformatf("%s w%0d all_free", tag, w), g_af, 32'(c == w));
      check_eq($sformatf("%s w%0d none_free", tag, w), g_nf, 32'(c == 0));
      check_eq($sformatf("%s w%0d two_free", tag, w), g_tf, 32'(c >= 2));
      check_eq($sformatf("%s w%0d err_code", tag, w), g_ec, 32'(m_ec[k]));
      check_eq($sformatf("%s w%0d err", tag, w), g_er, 32'(|m_ec[k]));
    end
  endtask

  // Inputs are driven 1 time unit after an edge and outputs checked 1 unit after the next edge.
  task automatic step(input string tag, input logic fl, input logic [1:0] av, input int a1, input int a2,
                      input logic [1:0] rv, input int r1, input int r2);
    flush = fl;
    alloc_valid = av; alloc_idx1 = 3'(a1); alloc_idx2 = 3'(a2);
    rel_valid = rv;   rel_idx1 = 3'(r1);   rel_idx2 = 3'(r2);
    @(posedge clock);
    #1;
    model_step(fl, av, a1, a2, rv, r1, r2);
    compare_all(tag);
  endtask

  task automatic mid_reset(input string tag);
    #1 reset = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    #1 reset = 1'b0;
  endtask

  function automatic logic coin(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    compare_all("reset");
    reset = 1'b0;

    step("idle0", 0, 2'b00, 0, 0, 2'b00, 0, 0);
    step("idle1", 0, 2'b00, 0, 0, 2'b00, 0, 0);
    check_eq("tp idle fv", 32'(fv8), 32'hFF);
    check_eq("tp idle cnt", 32'(cnt8), 32'd8);
    check_eq("tp idle all_free", 32'(af8), 32'd1);
    check_eq("tp idle two_free", 32'(tf8), 32'd1);
    check_eq("tp idle err", 32'(er8), 32'd0);

    step("alloc01", 0, 2'b11, 0, 1, 2'b00, 0, 0);
    check_eq("tp alloc01 fv", 32'(fv8), 32'hFC);
    check_eq("tp alloc01 cnt", 32'(cnt8), 32'd6);
    step("rel1", 0, 2'b00, 0, 0, 2'b01, 1, 0);
    check_eq("tp rel1 fv", 32'(fv8), 32'hFE);
    check_eq("tp rel1 cnt", 32'(cnt8), 32'd7);

    step("flush_a", 1, 2'b00, 0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) step("fill", 0, 2'b11, 2 * i, 2 * i + 1, 2'b00, 0, 0);
    check_eq("tp full none_free", 32'(nf8), 32'd1);
    check_eq("tp full two_free", 32'(tf8), 32'd0);
    check_eq("tp full cnt", 32'(cnt8), 32'd0);
    step("rel52", 0, 2'b00, 0, 0, 2'b11, 5, 2);
    check_eq("tp rel52 fv", 32'(fv8), 32'h24);
    check_eq("tp rel52 cnt", 32'(cnt8), 32'd2);
    check_eq("tp rel52 two_free", 32'(tf8), 32'd1);

    step("empty", 0, 2'b11, 2, 5, 2'b00, 0, 0);
    step("same3", 0, 2'b01, 3, 0, 2'b01, 3, 0);
    check_eq("tp same3 fv", 32'(fv8), 32'h08);
`ifdef SLOT_RELEASE_CHECK_EN
    check_eq("tp same3 busy", 32'(ec8[1]), 32'd1);
`endif

    mid_reset("rst_a");
    step("alloc4", 0, 2'b01, 4, 0, 2'b00, 0, 0);
    step("dblrel4", 0, 2'b00, 0, 0, 2'b11, 4, 4);
    check_eq("tp dblrel4 fv", 32'(fv8), 32'hFF);
    check_eq("tp dblrel4 cnt", 32'(cnt8), 32'd8);
`ifdef SLOT_RELEASE_CHECK_EN
    check_eq("tp dblrel4 err_code", 32'(ec8), 32'd1);
    check_eq("tp dblrel4 err", 32'(er8), 32'd1);
`else
    check_eq("tp dblrel4 err_code", 32'(ec8), 32'd0);
`endif
    step("flush_b", 1, 2'b00, 0, 0, 2'b00, 0, 0);
`ifdef SLOT_RELEASE_CHECK_EN
    check_eq("tp err sticky", 32'(er8), 32'd1);
`endif

    step("fill10", 0, 2'b11, 0, 1, 2'b00, 0, 0);
    step("fill10", 0, 2'b11, 2, 3, 2'b00, 0, 0);
    step("fill10", 0, 2'b11, 5, 6, 2'b00, 0, 0);
    step("fill10", 0, 2'b11, 7, 7, 2'b00, 0, 0);
    check_eq("tp pre-flush fv", 32'(fv8), 32'h10);
    step("flush_alloc4", 1, 2'b01, 4, 0, 2'b00, 0, 0);
    check_eq("tp flush fv", 32'(fv8), 32'hFF);
    check_eq("tp flush cnt", 32'(cnt8), 32'd8);
    mid_reset("rst_b");
    check_eq("tp async fv", 32'(fv8), 32'hFF);
    check_eq("tp async err", 32'(er8), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      int pa;
      int pr;
      logic fl;
      logic [1:0] av;
      logic [1:0] rv;
      pa = ((i / 48) % 2 == 0) ? 75 : 25;
      pr = 100 - pa;
      fl = ($urandom_range(0, 59) == 0);
      av = {coin(pa), coin(pa)};
      rv = {coin(pr), coin(pr)};
      step("rand", fl, av, $urandom_range(0, 7), $urandom_range(0, 7),
           rv, $urandom_range(0, 7), $urandom_range(0, 7));
      if (i % 700 == 699) mid_reset("rand_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/slot_release_tracker.md
Name: slot_release_tracker

Overview:
- Owns the free-slot bitmap for a WIDTH-entry structure such as an RS or LSQ.
- It is the release end of the allocation path. The allocator scans `free_vec` for up to two set bits and returns two indices plus valids.
- Each cycle this block applies up to 2 allocations (clears bits) and up to 2 releases (index → one-hot decode, sets bits).
- It keeps the registered bitmap, the free count and full/empty flags, and flags protocol violations.

Parameters:
- WIDTH, 8, number of tracked slots (≥2).
- IDX_W, $clog2(WIDTH), slot index width.
- CNT_W, $clog2(WIDTH+1), free-count width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous: return every slot to free
- alloc_valid  in  2  bit k = allocation k valid this cycle
- alloc_idx1  in  IDX_W  slot taken by allocation 0
- alloc_idx2  in  IDX_W  slot taken by allocation 1
- rel_valid  in  2  bit k = release k valid this cycle
- rel_idx1  in  IDX_W  slot released by port 0
- rel_idx2  in  IDX_W  slot released by port 1
- free_vec  out  WIDTH  registered bitmap, bit i = 1 means slot i free
- free_count  out  CNT_W  registered popcount of free_vec
- all_free  out  1  free_count == WIDTH
- none_free  out  1  free_count == 0
- two_free  out  1  free_count ≥ 2 (gates 2-wide dispatch)
- err  out  1  sticky protocol-violation flag
- err_code  out  3  sticky error-class bits: [0] double free, [1] alloc of busy slot, [2] index ≥ WIDTH

Behaviour:
- Reset (async, asserted): free_vec = all ones, free_count = WIDTH, all_free = 1, none_free = 0, two_free = 1, err = 0, err_code = 0.
- Decode:
  - rel_mask = onehot(rel_idx1)&rel_valid[0] | onehot(rel_idx2)&rel_valid[1].
  - alloc_mask is built the same way from the alloc ports.
  - Any index ≥ WIDTH decodes to zero.
- Next state: free_vec_n = (free_vec & ~alloc_mask) | rel_mask.
  - Release wins over allocate on the same index in the same cycle.
  - free_count_n = popcount(free_vec_n), computed combinationally and registered with free_vec.
  - free_count must never be tracked as a separate up/down counter.
- Latency: every alloc and release is visible on all outputs exactly 1 cycle later. There is no combinational path from inputs to outputs.
- flush: free_vec_n = all ones and free_count_n = WIDTH. Alloc and release on the same cycle are ignored. err and err_code are unchanged.
- Duplicates:
  - Two releases of the same index in one cycle set a single bit; the count rises by 1.
  - Two allocations of the same index clear a single bit.
- Boundaries:
  - none_free with alloc_valid ≠ 0 is an alloc-of-busy-slot error; the bitmap is unchanged by that alloc.
  - all_free with rel_valid ≠ 0 is a double-free error; the bitmap stays all ones.
- err and err_code are set on detection and cleared only by reset.
- Reset asserted mid-cycle overrides all inputs immediately.

Optional Feature:
- Macro: SLOT_RELEASE_CHECK_EN.
- Defined:
  - err_code[0] is set when a released index is already free in free_vec, or when both release ports carry the same valid index.
  - err_code[1] is set when an allocated index is not free in free_vec.
  - err_code[2] is set when any valid index ≥ WIDTH.
  - err = |err_code.
  - Checks are suppressed while flush = 1.
- Undefined: err and err_code are tied to 0, and no checker logic is synthesised. Bitmap behaviour is identical in both builds.

Test Plan (WIDTH=8):
- Reset, then idle 2 cycles → free_vec = 8'hFF, free_count = 8, all_free = 1, two_free = 1, err = 0.
- Alloc idx 0 and 1 together → next cycle free_vec = 8'hFC, count = 6. Then release idx 1 → free_vec = 8'hFE, count = 7.
- Allocate all 8 slots over 4 cycles → none_free = 1, two_free = 0, count = 0. Release idx 5 and 2 together → free_vec = 8'h24, count = 2, two_free = 1.
- From free_vec = 8'h00: alloc idx 3 and release idx 3 in the same cycle → free_vec = 8'h08. With the macro defined, err_code[1] = 1 (alloc of busy slot 3).
- With the macro defined: release idx 4 on both ports while slot 4 is busy → free_vec bit 4 set, count +1, err_code = 3'b001, err = 1, and it stays 1 after a later flush.
- With free_vec = 8'h10 and alloc of idx 4 on the flush cycle → next free_vec = 8'hFF, count = 8. Then assert reset mid-cycle → outputs return to reset values immediately, with no clock edge needed.
